// File: rtl/aud_rec_capture.sv
// -----------------------------------------------------------------------------
// aud_rec_capture
//   I2S capture stage feeding the SRAM write port. The codec ADC stream is
//   brought into the system clock domain, the left-channel word of every LR
//   frame is deserialised MSB first, and one sample plus a one-cycle write
//   strobe is produced per frame. Recording is steered by the debounced
//   record / pause / stop key pulses.
//
// Ports
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_start/i_pause/i_stop  one-cycle key pulses (stop > pause > start)
//   i_aud_bclk          codec bit clock (async, <= i_clk/4)
//   i_aud_lrck          codec ADC LR clock (async, 0 = left half)
//   i_aud_adcdat        codec serial data (async)
//   o_addr              SRAM address of the current / next sample
//   o_data              captured sample, valid while o_wr = 1, then held
//   o_wr                one-cycle SRAM write strobe
//   o_recording         high in ARM / SHIFT / WRITE
//   o_full              sticky, set once ADDR_MAX has been written
//   o_last_addr         last address written (0 before any write)
// -----------------------------------------------------------------------------
module aud_rec_capture #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF,
    parameter int                SYNC_N   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_aud_bclk,
    input  logic              i_aud_lrck,
    input  logic              i_aud_adcdat,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wr,
    output logic              o_recording,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_last_addr
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_PAUSED = 3'd4;

    // ---- stage p0: synchronisers on the three codec pins ----
    logic [SYNC_N-1:0] bclk_sync_p0;
    logic [SYNC_N-1:0] lrck_sync_p0;
    logic [SYNC_N-1:0] dat_sync_p0;
    logic              bclk_s;
    logic              lrck_s;
    logic              dat_s;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bclk_sync_p0 <= '0;
            lrck_sync_p0 <= '0;
            dat_sync_p0  <= '0;
        end else begin
            bclk_sync_p0 <= {bclk_sync_p0[SYNC_N-2:0], i_aud_bclk};
            lrck_sync_p0 <= {lrck_sync_p0[SYNC_N-2:0], i_aud_lrck};
            dat_sync_p0  <= {dat_sync_p0[SYNC_N-2:0], i_aud_adcdat};
        end
    end

    assign bclk_s = bclk_sync_p0[SYNC_N-1];
    assign lrck_s = lrck_sync_p0[SYNC_N-1];
    assign dat_s  = dat_sync_p0[SYNC_N-1];

    // ---- stage p1: registered edge detect, data bit travels with the BCLK rise ----
    logic bclk_prev;
    logic lrck_prev;
    logic bclk_rise_p1;
    logic lrck_fall_p1;
    logic lrck_rise_p1;
    logic dat_p1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bclk_prev    <= 1'b0;
            lrck_prev    <= 1'b0;
            bclk_rise_p1 <= 1'b0;
            lrck_fall_p1 <= 1'b0;
            lrck_rise_p1 <= 1'b0;
            dat_p1       <= 1'b0;
        end else begin
            bclk_prev    <= bclk_s;
            lrck_prev    <= lrck_s;
            bclk_rise_p1 <= bclk_s & ~bclk_prev;
            lrck_fall_p1 <= lrck_prev & ~lrck_s;
            lrck_rise_p1 <= ~lrck_prev & lrck_s;
            dat_p1       <= dat_s;
        end
    end

    // ---- stage p2: capture FSM, shift register and SRAM-side outputs ----
    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [CNT_W-1:0]  bitcnt;
    logic              delay_pending;

    assign shreg_next = {shreg[DATA_W-2:0], dat_p1};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bitcnt        <= '0;
            delay_pending <= 1'b0;
            o_addr        <= '0;
            o_data        <= '0;
            o_wr          <= 1'b0;
            o_full        <= 1'b0;
            o_last_addr   <= '0;
        end else begin
            o_wr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start && !i_pause && !o_full) begin
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (i_pause) begin
                        state <= ST_PAUSED;
                    end else if (lrck_fall_p1) begin
                        // Left half begins; the next BCLK rise is the I2S delay bit.
                        state         <= ST_SHIFT;
                        shreg         <= '0;
                        bitcnt        <= '0;
                        delay_pending <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (i_pause) begin
                        state <= ST_PAUSED;
                    end else if (lrck_rise_p1) begin
                        // Right half started before a full word: drop the partial sample.
                        state <= ST_ARM;
                    end else if (bclk_rise_p1) begin
                        if (delay_pending) begin
                            delay_pending <= 1'b0;
                        end else begin
                            shreg  <= shreg_next;
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == LAST_BIT) begin
                                // o_wr is registered together with the WRITE state so the
                                // strobe lines up exactly with the WRITE cycle.
                                state  <= ST_WRITE;
                                o_wr   <= 1'b1;
                                o_data <= shreg_next;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    o_last_addr <= o_addr;
                    if (o_addr == ADDR_MAX) begin
                        o_full <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        o_addr <= o_addr + 1'b1;
                        state  <= i_pause ? ST_PAUSED : ST_ARM;
                    end
                end
                ST_PAUSED: begin
                    if (i_start && !i_pause) begin
                        state <= ST_ARM;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Stop overrides everything above; a write already on the bus this
            // cycle still completes (o_last_addr update above is kept).
            if (i_stop) begin
                state  <= ST_IDLE;
                o_addr <= '0;
                o_full <= 1'b0;
                o_wr   <= 1'b0;
            end
        end
    end

    assign o_recording = (state == ST_ARM) || (state == ST_SHIFT) || (state == ST_WRITE);

endmodule

// File: tb/tb_aud_rec_capture.sv
// -----------------------------------------------------------------------------
// tb_aud_rec_capture
//   Directed bench for aud_rec_capture. Two instances share the codec pins:
//   "dut" with the full address space and "dut_s" with ADDR_MAX = 3 to reach
//   the full condition quickly. Expected writes are queued when a frame is
//   issued; per-instance monitors pop and compare on every write strobe.
// -----------------------------------------------------------------------------
module tb_aud_rec_capture;

    logic        clk;
    logic        rst;
    logic        start, pause, stop;
    logic        start_s, stop_s;
    logic        bclk, lrck, adcdat;

    logic [19:0] addr, last_addr;
    logic [15:0] data;
    logic        wr, recording, full;

    logic [19:0] addr_s, last_addr_s;
    logic [15:0] data_s;
    logic        wr_s, recording_s, full_s;

    int n_cmp = 0;
    int n_bad = 0;

    logic [35:0] q_main[$];
    logic [35:0] q_small[$];

    aud_rec_capture #(
        .DATA_W(16), .ADDR_W(20), .ADDR_MAX(20'hFFFFF), .SYNC_N(2)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_aud_bclk(bclk), .i_aud_lrck(lrck), .i_aud_adcdat(adcdat),
        .o_addr(addr), .o_data(data), .o_wr(wr),
        .o_recording(recording), .o_full(full), .o_last_addr(last_addr)
    );

    aud_rec_capture #(
        .DATA_W(16), .ADDR_W(20), .ADDR_MAX(20'h00003), .SYNC_N(2)
    ) dut_s (
        .i_clk(clk), .i_rst(rst),
        .i_start(start_s), .i_pause(1'b0), .i_stop(stop_s),
        .i_aud_bclk(bclk), .i_aud_lrck(lrck), .i_aud_adcdat(adcdat),
        .o_addr(addr_s), .o_data(data_s), .o_wr(wr_s),
        .o_recording(recording_s), .o_full(full_s), .o_last_addr(last_addr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: one pop per write strobe.
    always @(negedge clk) begin
        if (wr === 1'b1) begin
            if (q_main.size() == 0) begin
                chk("main_unexpected_wr", {12'd0, addr}, 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = q_main.pop_front();
                chk("main_wr_addr", {12'd0, addr}, {12'd0, e[35:16]});
                chk("main_wr_data", {16'd0, data}, {16'd0, e[15:0]});
            end
        end
    end

    always @(negedge clk) begin
        if (wr_s === 1'b1) begin
            if (q_small.size() == 0) begin
                chk("small_unexpected_wr", {12'd0, addr_s}, 32'hFFFF_FFFF);
            end else begin
                logic [35:0] e;
                e = q_small.pop_front();
                chk("small_wr_addr", {12'd0, addr_s}, {12'd0, e[35:16]});
                chk("small_wr_data", {16'd0, data_s}, {16'd0, e[15:0]});
            end
        end
    end

    // One I2S frame: 20 BCLK periods left (lrck=0), 20 right (lrck=1).
    // Slot 0 of each half is the delay bit, slots 1..16 carry the word MSB first.
    // BCLK half period = 4 system clocks. act: 0 none, 1 pause pulse, 2 reset pulse,
    // issued during the low phase of slot act_slot.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int act_slot, input int act);
        logic [15:0] w;
        int k;
        for (int s = 0; s < 40; s++) begin
            k    = s % 20;
            w    = (s < 20) ? l : r;
            lrck = (s >= 20);
            bclk = 1'b0;
            adcdat = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
            if (s == act_slot && act == 1) begin
                pause = 1'b1;
                @(negedge clk);
                pause = 1'b0;
                repeat (3) @(negedge clk);
            end else if (s == act_slot && act == 2) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_mid_wr", {31'd0, wr}, 32'd0);
                chk("rst_mid_addr", {12'd0, addr}, 32'd0);
                chk("rst_mid_data", {16'd0, data}, 32'd0);
                chk("rst_mid_rec", {31'd0, recording}, 32'd0);
                chk("rst_mid_full", {31'd0, full}, 32'd0);
                chk("rst_mid_last", {12'd0, last_addr}, 32'd0);
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            bclk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    // which: 0 start, 1 stop, 2 start_s, 3 stop_s
    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: start   = 1'b1;
            1: stop    = 1'b1;
            2: start_s = 1'b1;
            default: stop_s = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0; stop = 1'b0; start_s = 1'b0; stop_s = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        start_s = 1'b0; stop_s = 1'b0;
        bclk = 1'b0; lrck = 1'b1; adcdat = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_addr", {12'd0, addr}, 32'd0);
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_rec", {31'd0, recording}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_last", {12'd0, last_addr}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single frame A5C3, right half FFFF must not be captured
        pulse(0);
        chk("t1_rec_armed", {31'd0, recording}, 32'd1);
        q_main.push_back({20'd0, 16'hA5C3});
        send_frame(16'hA5C3, 16'hFFFF, -1, 0);
        chk("t1_addr_after", {12'd0, addr}, 32'd1);
        chk("t1_last", {12'd0, last_addr}, 32'd0);
        chk("t1_data_held", {16'd0, data}, 32'h0000A5C3);

        // 2: ramp 0..9 at addresses 0..9
        pulse(1);
        chk("t2_stop_addr", {12'd0, addr}, 32'd0);
        pulse(0);
        for (int i = 0; i < 10; i++) begin
            q_main.push_back({20'(i), 16'(i)});
            send_frame(16'(i), 16'hFFFF, -1, 0);
        end
        chk("t2_last", {12'd0, last_addr}, 32'd9);
        chk("t2_addr", {12'd0, addr}, 32'd10);

        // 3: pause at bit 8 of frame 3, resume writes at address 3
        pulse(1);
        pulse(0);
        for (int i = 0; i < 3; i++) begin
            q_main.push_back({20'(i), 16'h1000 + 16'(i)});
            send_frame(16'h1000 + 16'(i), 16'hFFFF, -1, 0);
        end
        send_frame(16'hDEAD, 16'hFFFF, 8, 1);
        chk("t3_addr_paused", {12'd0, addr}, 32'd3);
        chk("t3_rec_paused", {31'd0, recording}, 32'd0);
        send_frame(16'h5555, 16'hFFFF, -1, 0);
        chk("t3_addr_still", {12'd0, addr}, 32'd3);
        pulse(0);
        q_main.push_back({20'd3, 16'hBEEF});
        send_frame(16'hBEEF, 16'hFFFF, -1, 0);
        chk("t3_addr_resumed", {12'd0, addr}, 32'd4);
        chk("t3_last", {12'd0, last_addr}, 32'd3);

        // 5: stop in the same cycle as the write of address 5
        pulse(1);
        pulse(0);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    q_main.push_back({20'(i), 16'h2000 + 16'(i)});
                    send_frame(16'h2000 + 16'(i), 16'hFFFF, -1, 0);
                end
            end
            begin
                int t;
                t = 0;
                while (!(wr === 1'b1 && addr == 20'd5) && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                chk("t5_wr5_seen", {31'd0, (t < 5000)}, 32'd1);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                chk("t5_addr", {12'd0, addr}, 32'd0);
                chk("t5_last", {12'd0, last_addr}, 32'd5);
                chk("t5_rec", {31'd0, recording}, 32'd0);
            end
        join
        send_frame(16'h7777, 16'hFFFF, -1, 0);
        chk("t5_idle_rec", {31'd0, recording}, 32'd0);

        // 4: small instance, ADDR_MAX = 3
        pulse(2);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) q_small.push_back({20'(i), 16'h0300 + 16'(i)});
            send_frame(16'h0300 + 16'(i), 16'hFFFF, -1, 0);
        end
        chk("t4_full", {31'd0, full_s}, 32'd1);
        chk("t4_rec", {31'd0, recording_s}, 32'd0);
        chk("t4_addr_held", {12'd0, addr_s}, 32'd3);
        chk("t4_last", {12'd0, last_addr_s}, 32'd3);
        pulse(2);
        chk("t4_start_ignored", {31'd0, recording_s}, 32'd0);
        send_frame(16'h9999, 16'hFFFF, -1, 0);
        pulse(3);
        chk("t4_stop_full", {31'd0, full_s}, 32'd0);
        chk("t4_stop_addr", {12'd0, addr_s}, 32'd0);
        chk("t4_stop_last", {12'd0, last_addr_s}, 32'd3);

        // 6: reset in the middle of a shifting frame
        pulse(0);
        q_main.push_back({20'd0, 16'hC001});
        send_frame(16'hC001, 16'hFFFF, -1, 0);
        q_main.push_back({20'd1, 16'hC002});
        send_frame(16'hC002, 16'hFFFF, -1, 0);
        chk("t6_last_pre", {12'd0, last_addr}, 32'd1);
        send_frame(16'hC003, 16'hFFFF, 9, 2);
        send_frame(16'hC004, 16'hFFFF, -1, 0);
        chk("t6_addr_after", {12'd0, addr}, 32'd0);

        repeat (10) @(negedge clk);
        chk("main_queue_empty", 32'(q_main.size()), 32'd0);
        chk("small_queue_empty", 32'(q_small.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
